// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmit scheduler, 8N1 framing with a clock-enable baud divider.
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_sched #(
    parameter int BAUD_DIV = 10400
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       tx,
    output logic       busy,
    output logic       grant
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             tx_nxt, busy_nxt, ack0_nxt, ack1_nxt, grant_nxt;
    logic             win;
    logic             bit_last;

    assign bit_last = (cnt == CNT_LAST);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            grant   <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            tx      <= tx_nxt;
            busy    <= busy_nxt;
            ack0    <= ack0_nxt;
            ack1    <= ack1_nxt;
            grant   <= grant_nxt;
        end
    end

    // Every output is computed one cycle ahead so tx/busy/ack/grant leave straight from flops.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt + CNT_W'(1);
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        tx_nxt      = tx;
        busy_nxt    = busy;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        grant_nxt   = grant;
        win         = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req0 || req1) begin
                    // On contention the requester that was not served last wins.
                    win       = (req0 && req1) ? ~grant : req1;
                    grant_nxt = win;
                    shreg_nxt = win ? data1 : data0;
                    ack0_nxt  = ~win;
                    ack1_nxt  = win;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_last) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = 3'd0;
                    tx_nxt      = shreg[0];
                    state_nxt   = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_nxt    = ^shreg;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        tx_nxt      = shreg[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester transmit scheduler for the board UART. It arbitrates round-robin between two byte sources, the CPU peripheral write port and the debug/status source, and serialises the granted byte as one 8N1 frame on `tx`. Bit timing comes from an internal baud divider running as a clock-enable on `sysclk`, so no derived clock is generated. The block sits between the peripheral bus and the UART TX pin.

## Interface
- `BAUD_DIV`, default 10400: `sysclk` cycles per UART bit (100 MHz → ~9615 Bd). Must be ≥ 2.
- `sysclk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 has a byte; level, held until `ack0`.
- `data0`  in  8  requester 0 byte; valid while `req0` is high.
- `ack0`  out  1  one-cycle pulse: byte from requester 0 accepted.
- `req1`  in  1  requester 1 request; same rules as `req0`.
- `data1`  in  8  requester 1 byte.
- `ack1`  out  1  one-cycle pulse: byte from requester 1 accepted.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress.
- `grant`  out  1  index of the most recently accepted requester.

## Operation
- States: IDLE, START, DATA, STOP (plus PARITY, see Configuration).
- IDLE:
  - Requests are sampled every cycle.
  - If exactly one `reqN` is high, requester N wins.
  - If both are high, the winner is the requester not equal to `grant` (round-robin).
  - The winner's data is latched into the shift register, `grant` is set to N, and the state goes to START.
- Requests arriving in any non-IDLE state are ignored and are not queued. A request dropped before its ack is never sent.
- Byte, `grant` and `ackN` are all registered. `ackN` is high only in the first START cycle. The requester may change `data`/`req` from the cycle after ack.
- Bit counter:
  - Width is ceil(log2(BAUD_DIV)).
  - Cleared on entry to each state.
  - Each bit lasts exactly BAUD_DIV cycles; the state or bit advances when the counter reaches BAUD_DIV-1.
- Bit order:
  - START drives `tx`=0.
  - DATA drives bits 0..7, LSB first, using a 3-bit index. It exits to STOP after bit 7.
  - STOP drives `tx`=1, then returns to IDLE.
- `busy` = (state != IDLE).
- Reset values: `tx`=1, `busy`=0, `ack0`=`ack1`=0, `grant`=1 (so `req0` wins the first contention), state IDLE, counters 0.
- Reset mid-frame: on the next edge `tx`=1 and `busy`=0. The partial frame is abandoned and no ack is issued. A still-held request is re-accepted once reset is released.

## Timing
- Accept decision in cycle T (IDLE, request high):
  - `ackN`=1, `tx`=0 and `busy`=1 in cycle T+1.
  - Start bit occupies T+1..T+B (B = BAUD_DIV).
  - Data bit i occupies T+1+(i+1)B .. T+(i+2)B.
  - Stop bit occupies T+9B+1..T+10B.
- IDLE is re-entered at T+10B+1. That cycle can accept, so back-to-back frames have exactly one extra idle-high cycle. Consecutive start-bit edges are 10B+1 cycles apart.
- `tx` is a registered output with no combinational path from any input.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for BAUD_DIV cycles. Frame is 11 bits; spacing between start edges is 11B+1.
  - Undefined: plain 8N1 as described above, with no parity logic.

## Test plan
All scenarios use BAUD_DIV=4.
- Reset, then `req0`=1 with `data0`=0x55:
  - `ack0` pulses once, `grant`=0.
  - `tx` is 0×4, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1×4.
  - `busy` is high for exactly 40 cycles.
- `req0` and `req1` asserted in the same cycle, held until acked, `data0`=0xA5, `data1`=0x3C:
  - 0xA5 is sent first (`grant`=0), then 0x3C (`grant`=1).
  - Start edges are 41 cycles apart.
- Both requests held high continuously for four frames: `grant` sequence is 0,1,0,1 and `ack0`/`ack1` alternate.
- `req1` raised at cycle 10 of a `req0` frame and dropped at cycle 30: no `ack1` is issued, no second frame is sent, `tx` stays high after the stop bit.
- `reset` asserted at cycle 15 of a 0xFF frame with `req0` held:
  - Next cycle `tx`=1 and `busy`=0.
  - After release, a full fresh 0xFF frame is sent with a new `ack0`.
- With `UART_TX_PARITY_EN`, send 0x07:
  - Parity bit is 1.
  - Frame is 44 cycles: start 0, data 1,1,1,0,0,0,0,0, parity 1, stop 1.
